// File: rtl/lcd_line_timer.sv
// Dot/line timing generator: counts dots and scanlines, decodes LCD mode, LY
// compare, renderer draw strobe and the VBlank/STAT interrupt requests.
module lcd_line_timer #(
    parameter int DOTS_PER_LINE = 456,
    parameter int OAM_DOTS      = 80,
    parameter int XFER_DOTS     = 172,
    parameter int VISIBLE_LINES = 144,
    parameter int TOTAL_LINES   = 154
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       lcd_enable,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_ie,
    output logic [7:0] ly,
    output logic [1:0] mode,
    output logic       coincidence,
    output logic       drawline,
    output logic       vblank_irq,
    output logic       stat_irq
);

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_XFER   = 2'd3
    } mode_e;

    localparam logic [8:0] LAST_DOT     = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] XFER_START   = 9'(OAM_DOTS);
    localparam logic [8:0] HBLANK_START = 9'(OAM_DOTS + XFER_DOTS);
    localparam logic [7:0] LAST_LINE    = 8'(TOTAL_LINES - 1);
    localparam logic [7:0] VBLANK_LINE  = 8'(VISIBLE_LINES);

    logic [8:0] dot;
    logic [7:0] line;
    logic       stat_q;
    logic       active;
    logic       visible;
    logic       stat_cond;
    mode_e      mode_d;

    // Holding reset also blanks the decoded outputs immediately, with no clock edge needed.
    assign active  = lcd_enable & reset_n;
    assign visible = (line < VBLANK_LINE);

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        mode_d = MODE_HBLANK;
        if (active) begin
            if (!visible)                 mode_d = MODE_VBLANK;
            else if (dot < XFER_START)    mode_d = MODE_OAM;
            else if (dot < HBLANK_START)  mode_d = MODE_XFER;
            else                          mode_d = MODE_HBLANK;
        end
    end

    assign ly          = active ? line : 8'd0;
    assign mode        = mode_d;
    assign coincidence = active && (line == lyc);
    assign drawline    = active && visible && (dot == XFER_START);
    assign vblank_irq  = active && (line == VBLANK_LINE) && (dot == 9'd0);

    assign stat_cond = active && ((stat_ie[0] && (mode_d == MODE_HBLANK)) ||
                                  (stat_ie[1] && (mode_d == MODE_VBLANK)) ||
                                  (stat_ie[2] && (mode_d == MODE_OAM))    ||
                                  (stat_ie[3] && coincidence));
    // Only a rising edge of the combined condition requests; back-to-back sources merge.
    assign stat_irq = stat_cond && !stat_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dot    <= 9'd0;
            line   <= 8'd0;
            stat_q <= 1'b0;
        end else if (!lcd_enable) begin
            dot    <= 9'd0;
            line   <= 8'd0;
            stat_q <= 1'b0;
        end else begin
            stat_q <= stat_cond;
            if (dot == LAST_DOT) begin
                dot  <= 9'd0;
                line <= (line == LAST_LINE) ? 8'd0 : line + 8'd1;
            end else begin
                dot <= dot + 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_line_timer.sv
// Directed bench for lcd_line_timer: spot-check vector table over a full frame,
// event counts per frame, then LYC, disable/re-enable and async reset sequences.
module tb_lcd_line_timer;

    localparam int DPL   = 456;
    localparam int FRAME = 456 * 154;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       lcd_enable;
    logic [7:0] lyc;
    logic [3:0] stat_ie;
    logic [7:0] ly;
    logic [1:0] mode;
    logic       coincidence, drawline, vblank_irq, stat_irq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_dl, n_dl_off, n_vb, vb_at, n_si, si_at, n_co, n_nz;

    typedef struct {
        int         cyc;
        logic [7:0] ly;
        logic [1:0] mode;
        logic       dl;
        logic       vb;
        logic       si;
        logic       co;
    } vec_t;

    vec_t vecs[21];

    lcd_line_timer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .lcd_enable  (lcd_enable),
        .lyc         (lyc),
        .stat_ie     (stat_ie),
        .ly          (ly),
        .mode        (mode),
        .coincidence (coincidence),
        .drawline    (drawline),
        .vblank_irq  (vblank_irq),
        .stat_irq    (stat_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_dl = 0; n_dl_off = 0; n_vb = 0; vb_at = -1;
        n_si = 0; si_at = -1; n_co = 0; n_nz = 0;
    endtask

    // Accumulate event counts using a position model derived from the cycle number.
    task automatic sample();
        if (drawline) begin
            n_dl++;
            if (!((cyc % DPL) == 80 && ((cyc / DPL) % 154) < 144)) n_dl_off++;
        end
        if (vblank_irq)  begin n_vb++; vb_at = cyc; end
        if (stat_irq)    begin n_si++; si_at = cyc; end
        if (coincidence) n_co++;
        if (ly != 8'd0 || mode != 2'd0) n_nz++;
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
        cyc++;
        sample();
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        check({tag, ".ly"},   int'(ly),          int'(v.ly));
        check({tag, ".mode"}, int'(mode),        int'(v.mode));
        check({tag, ".dl"},   int'(drawline),    int'(v.dl));
        check({tag, ".vb"},   int'(vblank_irq),  int'(v.vb));
        check({tag, ".si"},   int'(stat_irq),    int'(v.si));
        check({tag, ".co"},   int'(coincidence), int'(v.co));
    endtask

    initial begin
        // cycle, ly, mode, drawline, vblank, stat_irq, coincidence  (lyc=5, stat_ie=0101)
        vecs[0]  = '{0,             8'd0,   2'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{79,            8'd0,   2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{80,            8'd0,   2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{251,           8'd0,   2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{252,           8'd0,   2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{455,           8'd0,   2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{456,           8'd1,   2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{536,           8'd1,   2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{2280,          8'd5,   2'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{2735,          8'd5,   2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{2736,          8'd6,   2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{80 + 143*456,  8'd143, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{65663,         8'd143, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{65664,         8'd144, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{65665,         8'd144, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{65744,         8'd144, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{69768,         8'd153, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{70223,         8'd153, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{70224,         8'd0,   2'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[19] = '{70304,         8'd0,   2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{70304,         8'd0,   2'd3, 1'b1, 1'b0, 1'b0, 1'b0};

        reset_n    = 1'b0;
        lcd_enable = 1'b1;
        lyc        = 8'd5;
        stat_ie    = 4'b0101;
        clear_counts();
        repeat (3) @(posedge clk);
        #3;
        check("reset.ly",   int'(ly),   0);
        check("reset.mode", int'(mode), 0);
        check("reset.dl",   int'(drawline), 0);

        // Release between edges: this is cycle 0 (line 0, dot 0).
        reset_n = 1'b1;
        cyc = 0;
        #1;
        sample();

        for (int i = 0; i < 21; i++) begin
            while (cyc < vecs[i].cyc) tick();
            check_outs($sformatf("vec%0d", i), vecs[i]);
            if (cyc == FRAME - 1 && i == 17) begin
                check("frame.drawline_count", n_dl, 144);
                check("frame.drawline_misplaced", n_dl_off, 0);
                check("frame.vblank_count", n_vb, 1);
                check("frame.vblank_at", vb_at, 65664);
                check("frame.stat_count", n_si, 145);
                check("frame.coinc_cycles", n_co, 456);
            end
        end

        // LYC interrupt only: single request at line 5 dot 0 of frame 2.
        stat_ie = 4'b1000;
        lyc     = 8'd5;
        #1;
        clear_counts();
        while (cyc < FRAME + 7 * DPL) tick();
        check("lyc.stat_count", n_si, 1);
        check("lyc.stat_at", si_at, FRAME + 5 * DPL);
        check("lyc.coinc_cycles", n_co, 456);
        check("lyc.ly_now", int'(ly), 7);
        lyc = 8'd7;
        #1;
        check("lyc_live.coinc", int'(coincidence), 1);
        check("lyc_live.stat_irq", int'(stat_irq), 1);
        lyc = 8'd200;
        #1;
        clear_counts();
        repeat (DPL) tick();
        check("lyc200.stat_count", n_si, 0);
        check("lyc200.coinc_cycles", n_co, 0);

        // Disable mid-line at line 10 dot 100, idle 1000 cycles, re-enable.
        while (cyc < FRAME + 10 * DPL + 100) tick();
        check("predis.ly", int'(ly), 10);
        check("predis.mode", int'(mode), 3);
        lcd_enable = 1'b0;
        #1;
        check("dis_now.ly", int'(ly), 0);
        clear_counts();
        tick();
        check("dis.ly", int'(ly), 0);
        check("dis.mode", int'(mode), 0);
        repeat (999) tick();
        check("dis.events", n_dl + n_vb + n_si + n_co + n_nz, 0);
        lcd_enable = 1'b1;
        #1;
        check("reen.ly", int'(ly), 0);
        check("reen.mode", int'(mode), 2);
        check("reen.dl", int'(drawline), 0);
        clear_counts();
        repeat (79) tick();
        check("reen.no_early_dl", n_dl, 0);
        tick();
        check("reen.dl80", int'(drawline), 1);
        check("reen.ly80", int'(ly), 0);
        check("reen.mode80", int'(mode), 3);

        // Asynchronous reset mid-frame, then restart timing.
        lyc = 8'd0;
        repeat (3000) tick();
        check("prerst.ly", int'(ly), 6);
        reset_n = 1'b0;
        #1;
        check("rst_async.ly", int'(ly), 0);
        check("rst_async.mode", int'(mode), 0);
        check("rst_async.coinc", int'(coincidence), 0);
        check("rst_async.stat", int'(stat_irq), 0);
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b1;
        cyc = 0;
        #1;
        check("rel.mode", int'(mode), 2);
        check("rel.coinc", int'(coincidence), 1);
        check("rel.stat", int'(stat_irq), 1);
        repeat (80) tick();
        check("rel.dl80", int'(drawline), 1);
        check("rel.mode80", int'(mode), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
